// File: rtl/an_encoder_n29_tile4x4.sv
// AN (A=29) encoder: packs 16 serial codewords into a row-major 4x4 tile on a valid/ready bus.
// Optional fault injection on the presented tile when AN_ERR_INJ_EN is defined.
module an_encoder_n29_tile4x4 #(
  parameter int MSG_W   = 10,
  parameter int CW_W    = 14,
  parameter int MAX_MSG = 564
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               msg_valid,
  output logic               msg_ready,
  input  logic [MSG_W-1:0]   msg_data,
  output logic               tile_valid,
  input  logic               tile_ready,
  output logic [16*CW_W-1:0] cw_bus,
  output logic               tile_range_err
`ifdef AN_ERR_INJ_EN
  ,
  input  logic               inj_en,
  input  logic [3:0]         inj_slot,
  input  logic [3:0]         inj_bit
`endif
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t          state_reg;
  logic [3:0]      cnt_reg;
  logic            range_err_reg;
  logic [CW_W-1:0] slot_reg [16];

  // Product kept one bit wider than a codeword so overflow is visible, never dropped.
  logic [CW_W:0]   msg_ext;
  logic [CW_W:0]   product;
  logic            over;
  logic [CW_W-1:0] codeword;

  assign msg_ext  = {{(CW_W+1-MSG_W){1'b0}}, msg_data};
  assign product  = (msg_ext << 4) + (msg_ext << 3) + (msg_ext << 2) + msg_ext;
  assign over     = product[CW_W] | (msg_data > MSG_W'(MAX_MSG));
  assign codeword = over ? '0 : product[CW_W-1:0];

  assign msg_ready      = (state_reg == FILL);
  assign tile_valid     = (state_reg == HOLD);
  assign tile_range_err = range_err_reg;

`ifdef AN_ERR_INJ_EN
  logic       inj_en_reg;
  logic [3:0] inj_slot_reg;
  logic [3:0] inj_bit_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= FILL;
      cnt_reg       <= '0;
      range_err_reg <= 1'b0;
      for (int i = 0; i < 16; i++) slot_reg[i] <= '0;
`ifdef AN_ERR_INJ_EN
      inj_en_reg    <= 1'b0;
      inj_slot_reg  <= '0;
      inj_bit_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        FILL: begin
          if (msg_valid) begin
            slot_reg[cnt_reg] <= codeword;
            cnt_reg           <= cnt_reg + 4'd1;
            // The first accept of a tile starts a fresh error flag.
            range_err_reg     <= (cnt_reg == 4'd0) ? over : (range_err_reg | over);
            if (cnt_reg == 4'd15) begin
              state_reg <= HOLD;
`ifdef AN_ERR_INJ_EN
              inj_en_reg   <= inj_en;
              inj_slot_reg <= inj_slot;
              inj_bit_reg  <= inj_bit;
`endif
            end
          end
        end
        HOLD: begin
          if (tile_ready) state_reg <= FILL;
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_slot
      logic [CW_W-1:0] flip;
`ifdef AN_ERR_INJ_EN
      // Flip only while the tile is presented; the stored slot stays intact.
      assign flip = (tile_valid && inj_en_reg && inj_slot_reg == 4'(gi) && inj_bit_reg < 4'(CW_W))
                    ? (CW_W'(1) << inj_bit_reg) : '0;
`else
      assign flip = '0;
`endif
      assign cw_bus[CW_W*gi +: CW_W] = slot_reg[gi] ^ flip;
    end
  endgenerate

endmodule

// File: tb/tb_an_encoder_n29_tile4x4.sv
// Self-checking bench for an_encoder_n29_tile4x4 with a behavioural tile model.
// Define AN_ERR_INJ_EN to also exercise the injection ports.
module tb_an_encoder_n29_tile4x4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic [9:0]   msg_data = '0;
  logic         tile_valid;
  logic         tile_ready = 1'b0;
  logic [223:0] cw_bus;
  logic         tile_range_err;
`ifdef AN_ERR_INJ_EN
  logic         inj_en = 1'b0;
  logic [3:0]   inj_slot = '0;
  logic [3:0]   inj_bit = '0;
`endif

  int checks = 0;
  int errors = 0;
  int msgs [16];
  bit inj_exp = 0;
  int inj_slot_exp = 0;
  int inj_bit_exp = 0;

  an_encoder_n29_tile4x4 dut (
    .clk(clk), .rst(rst),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .cw_bus(cw_bus), .tile_range_err(tile_range_err)
`ifdef AN_ERR_INJ_EN
    , .inj_en(inj_en), .inj_slot(inj_slot), .inj_bit(inj_bit)
`endif
  );

  always #5 clk = ~clk;

  function automatic int model_cw(input int m);
    return (m <= 564) ? m * 29 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed msgs[0..15] with random idle gaps of up to gap_max cycles.
  task automatic fill_tile(input int gap_max);
    for (int k = 0; k < 16; k++) begin
      msg_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) tick();
      checks++;
      if (msg_ready !== 1'b1 || tile_valid !== 1'b0) begin
        errors++;
        $display("FAIL fill_ready slot %0d: got ready=%b valid=%b, expected ready=1 valid=0",
                 k, msg_ready, tile_valid);
      end
      msg_valid = 1'b1;
      msg_data  = 10'(msgs[k]);
      tick();
    end
    msg_valid = 1'b0;
  endtask

  task automatic check_tile(input string name);
    bit err_exp = 0;
    checks++;
    if (tile_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s tile_valid: got %b expected 1", name, tile_valid);
    end
    for (int k = 0; k < 16; k++) begin
      int exp_cw = model_cw(msgs[k]);
      int got_cw = int'(cw_bus[14*k +: 14]);
      if (msgs[k] > 564) err_exp = 1;
      if (inj_exp && k == inj_slot_exp && inj_bit_exp < 14) exp_cw = exp_cw ^ (1 << inj_bit_exp);
      checks++;
      if (got_cw !== exp_cw) begin
        errors++;
        $display("FAIL %s slot %0d: got %0d expected %0d", name, k, got_cw, exp_cw);
      end
    end
    checks++;
    if (tile_range_err !== err_exp) begin
      errors++;
      $display("FAIL %s range_err: got %b expected %b", name, tile_range_err, err_exp);
    end
    $display("tile %s checked", name);
  endtask

  task automatic take_tile(input int wait_cycles);
    logic [223:0] snap = cw_bus;
    logic         err_snap = tile_range_err;
    repeat (wait_cycles) begin
      tick();
      checks++;
      if (msg_ready !== 1'b0 || tile_valid !== 1'b1 || cw_bus !== snap || tile_range_err !== err_snap) begin
        errors++;
        $display("FAIL hold_stable: got ready=%b valid=%b bus_same=%b, expected 0 1 1",
                 msg_ready, tile_valid, cw_bus === snap);
      end
    end
    tile_ready = 1'b1;
    tick();
    tile_ready = 1'b0;
    checks++;
    if (tile_valid !== 1'b0 || msg_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_transfer: got valid=%b ready=%b expected 0 1", tile_valid, msg_ready);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    msg_valid = 1'b1;
    msg_data  = 10'd5;
    repeat (2) tick();
    checks++;
    if (msg_ready !== 1'b1 || tile_valid !== 1'b0 || cw_bus !== '0 || tile_range_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b valid=%b bus=%h err=%b expected 1 0 0 0",
               msg_ready, tile_valid, cw_bus, tile_range_err);
    end
    msg_valid = 1'b0;
    rst = 1'b0;
    tick();
    msg_valid = 1'b1;
    msg_data  = 10'd7;
    tick();
    msg_valid = 1'b0;
    checks++;
    if (cw_bus[13:0] !== 14'd203 || cw_bus[223:14] !== '0 || tile_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_accept: got slot0=%0d rest_zero=%b valid=%b expected 203 1 0",
               cw_bus[13:0], cw_bus[223:14] === '0, tile_valid);
    end
    pulse_reset();
    $display("reset test done");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 16; k++) msgs[k] = k;
    fill_tile(0);
    check_tile("seq");
  endtask

  task automatic test_backpressure();
    msg_valid = 1'b1;
    msg_data  = 10'd9;
    take_tile(5);
    msg_valid = 1'b0;
  endtask

  task automatic test_range();
    for (int k = 0; k < 16; k++) msgs[k] = $urandom_range(0, 564);
    msgs[3] = 565;
    msgs[4] = 564;
    fill_tile(1);
    check_tile("range");
    take_tile(0);
    for (int k = 0; k < 16; k++) msgs[k] = $urandom_range(0, 564);
    fill_tile(1);
    check_tile("clean_after_range");
    take_tile(1);
  endtask

  task automatic test_reset_midfill();
    for (int k = 0; k < 7; k++) begin
      msg_valid = 1'b1;
      msg_data  = 10'($urandom_range(1, 1023));
      tick();
    end
    msg_valid = 1'b0;
    pulse_reset();
    checks++;
    if (tile_valid !== 1'b0 || msg_ready !== 1'b1 || cw_bus !== '0 || tile_range_err !== 1'b0) begin
      errors++;
      $display("FAIL midfill_reset: got valid=%b ready=%b bus=%h err=%b expected 0 1 0 0",
               tile_valid, msg_ready, cw_bus, tile_range_err);
    end
    for (int k = 0; k < 16; k++) msgs[k] = 1;
    fill_tile(0);
    check_tile("after_reset");
    // Reset while holding must drop the tile at once.
    pulse_reset();
    checks++;
    if (tile_valid !== 1'b0 || cw_bus !== '0) begin
      errors++;
      $display("FAIL hold_reset: got valid=%b bus=%h expected 0 0", tile_valid, cw_bus);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 16; k++)
        msgs[k] = ($urandom_range(0, 7) == 0) ? $urandom_range(565, 1023) : $urandom_range(0, 564);
      fill_tile(2);
      check_tile($sformatf("rand%0d", t));
      take_tile($urandom_range(0, 3));
    end
  endtask

`ifdef AN_ERR_INJ_EN
  task automatic test_injection();
    for (int k = 0; k < 16; k++) msgs[k] = 1;
    inj_en = 1'b1; inj_slot = 4'd5; inj_bit = 4'd0;
    inj_exp = 1; inj_slot_exp = 5; inj_bit_exp = 0;
    fill_tile(0);
    inj_en = 1'b0;
    check_tile("inject");
    take_tile(2);
    inj_en = 1'b1; inj_slot = 4'd9; inj_bit = 4'd14;
    inj_slot_exp = 9; inj_bit_exp = 14;
    fill_tile(0);
    inj_en = 1'b0;
    check_tile("inject_nobit");
    take_tile(0);
    inj_exp = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_range();
    test_reset_midfill();
    test_random();
`ifdef AN_ERR_INJ_EN
    test_injection();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
